// File: rtl/sel_scanner.sv
// sel_scanner: walks a 3-bit select code over the channels enabled in mask.
// Each enabled channel is held for DWELL cycles. The first cycle of each new
// scan pass is flagged on wrap. All outputs come straight from flops.
module sel_scanner #(
    parameter int DWELL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] mask,
    output logic [2:0] sel,
    output logic       sel_valid,
    output logic       wrap,
    output logic       busy
);

    // The dwell counter is never narrower than one bit, so DWELL=1 still has a counter.
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      sel_q, sel_d;
    logic            wrap_q, wrap_d;
    logic            act_q, act_d;
    logic [2:0]      first_sel;
    logic [2:0]      next_sel;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (m[k]) r = 3'(k);
        end
        return r;
    endfunction

    // Next set bit strictly above cur, searching circularly. Offset 8 lands back on cur,
    // so a mask holding only cur returns cur itself.
    function automatic logic [2:0] next_set(input logic [7:0] m, input logic [2:0] cur);
        logic [2:0] r;
        logic [2:0] idx;
        logic       found;
        r     = cur;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            idx = cur + 3'(k);
            if (!found && m[idx]) begin
                r     = idx;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    assign first_sel = lowest_set(mask);
    assign next_sel  = next_set(mask, sel_q);

    // State and output registers; reset forces the idle values without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= 3'd0;
            wrap_q  <= 1'b0;
            act_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            wrap_q  <= wrap_d;
            act_q   <= act_d;
        end
    end

    // Next-state and next-output logic. Exit (stop or empty mask) outranks an advance,
    // so leaving SCAN never produces a wrap pulse.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        wrap_d  = 1'b0;
        act_d   = act_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                sel_d = 3'd0;
                act_d = 1'b0;
                if (start && !stop && (mask != 8'd0)) begin
                    state_d = SCAN;
                    sel_d   = first_sel;
                    wrap_d  = 1'b1;
                    act_d   = 1'b1;
                end
            end
            SCAN: begin
                if (stop || (mask == 8'd0)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    sel_d   = 3'd0;
                    act_d   = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d  = '0;
                    sel_d  = next_sel;
                    wrap_d = (next_sel <= sel_q);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                sel_d   = 3'd0;
                act_d   = 1'b0;
            end
        endcase
    end

    assign sel       = sel_q;
    assign sel_valid = act_q;
    assign busy      = act_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_sel_scanner.sv
// tb_sel_scanner: four scanners with DWELL 1..4 share one set of inputs and are
// compared every cycle against a channel-list reference model.
module tb_sel_scanner;

    localparam int NI = 4;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic [7:0] mask;

    logic [2:0] sel_o [NI];
    logic       sv_o  [NI];
    logic       wr_o  [NI];
    logic       bz_o  [NI];

    int n_cmp;
    int n_err;

    // reference model: per instance, active flag, shown channel, cycles it has been shown
    bit       m_act [NI];
    int       m_sel [NI];
    int       m_age [NI];
    bit       m_wrap[NI];

    // clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sel_scanner #(.DWELL(g + 1)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start),
            .stop      (stop),
            .mask      (mask),
            .sel       (sel_o[g]),
            .sel_valid (sv_o[g]),
            .wrap      (wr_o[g]),
            .busy      (bz_o[g])
        );
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [7:0] m);
        for (int k = 0; k < 8; k++) if (m[k]) return k;
        return 0;
    endfunction

    // circular search for the next enabled channel after s (s itself only if alone)
    function automatic int next_ch(input logic [7:0] m, input int s);
        int j;
        for (int k = 1; k <= 8; k++) begin
            j = (s + k) % 8;
            if (m[j]) return j;
        end
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_act[i] = 0; m_sel[i] = 0; m_age[i] = 0; m_wrap[i] = 0;
        end
    endtask

    // advance the model by one clock edge using the currently applied inputs
    task automatic model_edge();
        int dw;
        int nx;
        for (int i = 0; i < NI; i++) begin
            dw = i + 1;
            if (rst) begin
                m_act[i] = 0; m_sel[i] = 0; m_age[i] = 0; m_wrap[i] = 0;
            end else if (!m_act[i]) begin
                m_wrap[i] = 0;
                if (start && !stop && mask != 8'd0) begin
                    m_act[i] = 1; m_sel[i] = lowest(mask); m_age[i] = 0; m_wrap[i] = 1;
                end
            end else if (stop || mask == 8'd0) begin
                m_act[i] = 0; m_sel[i] = 0; m_age[i] = 0; m_wrap[i] = 0;
            end else begin
                m_age[i]++;
                m_wrap[i] = 0;
                if (m_age[i] == dw) begin
                    nx = next_ch(mask, m_sel[i]);
                    m_wrap[i] = (nx <= m_sel[i]);
                    m_sel[i] = nx;
                    m_age[i] = 0;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("%s sel d%0d", tag, i + 1), 8'(sel_o[i]), 8'(m_sel[i]));
            check($sformatf("%s sel_valid d%0d", tag, i + 1), 8'(sv_o[i]), 8'(m_act[i]));
            check($sformatf("%s wrap d%0d", tag, i + 1), 8'(wr_o[i]), 8'(m_wrap[i]));
            check($sformatf("%s busy d%0d", tag, i + 1), 8'(bz_o[i]), 8'(m_act[i]));
        end
    endtask

    // driver: one clock, model follows the edge, outputs checked on the falling edge
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic run(input string tag, input int n);
        for (int c = 0; c < n; c++) step(tag);
    endtask

    task automatic pulse_start(input string tag, input logic [7:0] m);
        mask  = m;
        start = 1'b1;
        step(tag);
        start = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        mask  = 8'd0;
        model_reset();
        run("reset", 2);
        rst = 1'b0;
        run("idle", 2);

        // full mask: every channel in order, wrap at each return to 0
        pulse_start("ff", 8'hFF);
        run("ff", 70);
        stop = 1'b1; step("ff stop"); stop = 1'b0;

        // sparse mask 2,5,7
        pulse_start("a4", 8'b1010_0100);
        run("a4", 30);
        stop = 1'b1; step("a4 stop"); stop = 1'b0;

        // single channel: sel parked, wrap every DWELL cycles
        pulse_start("10", 8'h10);
        run("10", 25);

        // mask forced empty mid-scan exits after one edge
        mask = 8'd0; step("mask0");
        run("mask0 idle", 2);

        // start with empty mask, and start with stop, both stay idle
        start = 1'b1; mask = 8'd0; step("start m0");
        mask = 8'hFF; stop = 1'b1; step("start+stop"); step("start+stop");
        start = 1'b0; stop = 1'b0;

        // stop on the DWELL=4 advance cycle, then restart from the lowest channel
        pulse_start("adv", 8'b0110_1000);
        run("adv", 3);
        stop = 1'b1; step("stop adv"); stop = 1'b0;
        pulse_start("restart", 8'b0110_1000);
        run("restart", 8);

        // held start restarts on the edge after a stop exit
        start = 1'b1; stop = 1'b1; step("held stop");
        stop = 1'b0; step("held restart"); start = 1'b0;
        run("held run", 4);
        stop = 1'b1; step("held end"); stop = 1'b0;

        // asynchronous reset between edges with every instance on channel 5
        pulse_start("ch5", 8'h20);
        run("ch5", 3);
        #2 rst = 1'b1;
        model_reset();
        #1 check_all("arst");
        step("arst hold");
        rst = 1'b0;
        run("post arst", 2);
        pulse_start("resume", 8'b1110_0010);
        run("resume", 12);

        // random traffic
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 7) == 0)
                mask = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            start = ($urandom_range(0, 3) == 0);
            stop  = ($urandom_range(0, 19) == 0);
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sel_scanner.md
SEL_SCANNER -- requirements
Module: sel_scanner

Interface
REQ-001 The block SHALL have parameter DWELL, default 4, giving the number of clock cycles each select value is held; legal range 1..256.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1: reset is asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, a level request to begin scanning, sampled in IDLE.
REQ-005 The block SHALL have port stop, input, 1, a level request to end scanning, sampled in SCAN.
REQ-006 The block SHALL have port mask, input, 8, the channel-enable vector; bit i=1 means select value i is visited.
REQ-007 The block SHALL have port sel, output, 3, the registered select code that drives the downstream 3-to-8 decoder.
REQ-008 The block SHALL have port sel_valid, output, 1, high whenever sel is an actively scanned channel.
REQ-009 The block SHALL have port wrap, output, 1, a one-cycle pulse marking the start of a new scan pass.
REQ-010 The block SHALL have port busy, output, 1, high in state SCAN.

Function
REQ-011 The block SHALL implement a two-state machine, IDLE and SCAN, plus a dwell counter of ceil(log2(DWELL)) bits (1 bit minimum).
REQ-012 In IDLE the outputs SHALL be sel=0, sel_valid=0, wrap=0, busy=0, and the dwell counter SHALL be 0.
REQ-013 IDLE->SCAN SHALL occur on the edge where start=1, stop=0 and mask!=0; at that edge sel loads the lowest set bit index of mask, the counter is cleared, and wrap is asserted for that first cycle.
REQ-014 start=1 with mask=0 SHALL leave the block in IDLE.
REQ-015 start and stop both high in IDLE SHALL leave the block in IDLE, so stop wins.
REQ-016 In SCAN, sel_valid and busy SHALL be 1, and the counter SHALL increment each cycle.
REQ-017 When the counter equals DWELL-1, the next edge SHALL clear the counter and advance sel to the next set bit of mask strictly above sel, searching circularly 7->0.
REQ-018 The new sel SHALL therefore be visible exactly DWELL cycles after the previous one.
REQ-019 If the advance finds no set bit above sel, so the search wraps to an index less than or equal to sel, the block SHALL assert wrap for exactly the first cycle of the new sel.
REQ-020 With a single bit set in mask, sel SHALL stay constant and wrap SHALL pulse once every DWELL cycles.
REQ-021 For DWELL=1, sel SHALL advance every cycle.
REQ-022 mask SHALL be sampled combinationally at each advance edge; a cleared bit for the current sel does not cut its dwell short.
REQ-023 stop=1 in SCAN SHALL move the block to IDLE on the next edge, with the REQ-012 outputs, regardless of the counter value.
REQ-024 mask=0 at any edge in SCAN SHALL move the block to IDLE on that edge, as if stop were asserted.
REQ-025 stop takes priority over an advance in the same cycle, so there is no wrap pulse on exit.
REQ-026 A start held high after returning to IDLE SHALL restart the scan on the following edge.
REQ-027 All outputs SHALL be driven directly from registers, with no combinational path from the inputs to the outputs.

Reset
REQ-028 Asserting rst SHALL immediately, without waiting for clk, force IDLE, counter=0, sel=0, sel_valid=0, wrap=0 and busy=0.
REQ-029 Reset mid-scan SHALL abandon the pass.
REQ-030 After rst is released, the block SHALL remain in IDLE until a qualifying start.

Verification
REQ-031 Test: DWELL=4, mask=8'hFF, start pulse -> sel steps 0,1,...,7,0, each held 4 cycles; wrap is high on the first cycle of sel=0 both times; sel_valid=1 throughout.
REQ-032 Test: mask=8'b1010_0100, DWELL=2 -> sel sequence 2,5,7,2 at 2-cycle spacing; wrap on the first cycle of each 2.
REQ-033 Test: mask=8'h10, DWELL=3 -> sel held at 4; wrap pulses every 3 cycles; busy=1.
REQ-034 Test: start with mask=0 -> stays IDLE. start+stop together -> stays IDLE. mask forced to 0 mid-scan -> sel=0 and sel_valid=0 after one edge.
REQ-035 Test: stop asserted on the advance cycle (counter=DWELL-1) -> IDLE next edge with wrap=0; re-start -> sel equals the lowest set bit again.
REQ-036 Test: rst asserted between clock edges during scan with sel=5 -> all outputs are 0 before the next edge; after release, start resumes from the lowest enabled channel; DWELL=1 run gives sel changing every cycle.
